// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        PULSE,
        DONE
    } nes_state_t;

    localparam int NES_BITS    = 8;
    localparam int LATCH_TICKS = 2;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_tick.sv
// Protocol tick generator: counts 0..TICK_DIV-1, flags the last cycle of each tick.
module nes_tick #(
    parameter int TICK_DIV = 151
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick_end
);

    localparam logic [9:0] LAST = 10'(TICK_DIV - 1);

    logic [9:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 10'd1;
    end

    assign tick_end = (cnt == LAST);

endmodule

// File: rtl/nes_reader.sv
// NES pad serial reader: drives LATCH/CLOCK, shifts in 8 buttons, presents an active-high word.
// Optional NES_SYNC_EN adds a 2-flop synchronizer on nes_data.
module nes_reader
    import nes_pkg::*;
#(
    parameter int TICK_DIV = 151
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    nes_state_t        state;
    logic [2:0]        bit_idx;
    logic [6:0]        shift;   // first 7 bits; the 8th goes straight into buttons
    logic              data_s;
    logic              tick_end;
    logic              adv;
    logic              tick_clr;

`ifdef NES_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sync <= 2'b11;
        else
            sync <= {sync[0], nes_data};
    end
    assign data_s = sync[1];
`else
    assign data_s = nes_data;
`endif

    // Counter restarts on every state change and is held clear while idle.
    always_comb begin
        adv = 1'b0;
        if (tick_end) begin
            case (state)
                LATCH:   adv = (bit_idx == 3'(LATCH_TICKS - 1));
                SAMPLE:  adv = 1'b1;
                PULSE:   adv = 1'b1;
                default: adv = 1'b0;
            endcase
        end
        tick_clr = (state == IDLE) || adv;
    end

    nes_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (tick_clr),
        .tick_end (tick_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift     <= '0;
            buttons   <= '0;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        state     <= LATCH;
                        bit_idx   <= '0;
                        nes_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                // bit_idx doubles as the latch tick count here
                LATCH: begin
                    if (tick_end) begin
                        if (bit_idx == 3'(LATCH_TICKS - 1)) begin
                            state     <= SAMPLE;
                            bit_idx   <= '0;
                            nes_latch <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                SAMPLE: begin
                    if (tick_end) begin
                        shift <= {shift[5:0], ~data_s};
                        if (bit_idx == 3'(NES_BITS - 1)) begin
                            state   <= DONE;
                            buttons <= {shift, ~data_s};
                            valid   <= 1'b1;
                        end else begin
                            state   <= PULSE;
                            bit_idx <= bit_idx + 3'd1;
                            nes_clk <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (tick_end) begin
                        state   <= SAMPLE;
                        nes_clk <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_reader.sv
// Randomized scoreboard bench for nes_reader with a behavioural NES pad model.
module tb_nes_reader;

    localparam int T        = 4;
    localparam int BUSY_LEN = 17 * T + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    wire        nes_data;
    logic       nes_latch, nes_clk, valid, busy;
    logic [7:0] buttons;

    nes_reader #(.TICK_DIV(T)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .buttons   (buttons),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad: LATCH loads the pressed word, each CLOCK rise exposes the next button.
    logic [7:0] pad_word = 8'h00;
    logic [7:0] pad_sr   = 8'h00;
    logic       pad_mode = 1'b0;
    logic       hold_val = 1'b1;
    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) pad_sr <= pad_word;
        else           pad_sr <= {pad_sr[6:0], 1'b0};
    end
    assign nes_data = pad_mode ? hold_val : ~pad_sr[7];

    int n_pass = 0, n_chk = 0;
    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    endtask

    typedef struct { logic [7:0] word; int due; } exp_t;
    exp_t       sb[$];
    exp_t       e;
    logic [7:0] last_word = 8'h00;
    int         n_polls = 0;
    int         valid_cnt = 0;

    // Monitor
    int   lat_cnt = 0, clk_hi = 0, clk_pulses = 0, busy_cnt = 0;
    logic clk_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            lat_cnt = 0; clk_hi = 0; clk_pulses = 0; busy_cnt = 0;
            clk_prev = 1'b0;
            last_word = 8'h00;
        end else begin
            if (nes_latch) lat_cnt++;
            if (nes_clk) clk_hi++;
            if (nes_clk && !clk_prev) clk_pulses++;
            clk_prev = nes_clk;
            if (busy) busy_cnt++;
            if (valid) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("buttons", int'(buttons), int'(e.word));
                    check("valid_latency", cyc, e.due);
                    check("latch_cycles", lat_cnt, 2 * T);
                    check("clk_pulses", clk_pulses, 7);
                    check("clk_high_cycles", clk_hi, 7 * T);
                    check("busy_len", busy_cnt, BUSY_LEN);
                    last_word = e.word;
                end
                lat_cnt = 0; clk_hi = 0; clk_pulses = 0; busy_cnt = 0;
            end else begin
                check("buttons_hold", int'(buttons), int'(last_word));
            end
        end
    end

    // Caller is at a negedge. mode=1 holds nes_data at hv instead of the pad model.
    task automatic poll(input logic [7:0] w, input logic mode, input logic hv,
                        input bit extra, input int gap);
        int n;
        logic [7:0] expw;
        pad_word = w; pad_mode = mode; hold_val = hv;
        expw = mode ? (hv ? 8'h00 : 8'hFF) : w;
        start = 1'b1;
        n = cyc;
        sb.push_back('{expw, n + BUSY_LEN});
        n_polls++;
        @(negedge clk); start = 1'b0;
        if (extra) begin
            while (cyc < n + 20) @(negedge clk);
            start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        while (cyc < n + BUSY_LEN) @(negedge clk);
        if (extra) start = 1'b1;   // lands on the DONE cycle
        @(negedge clk); start = 1'b0;
        if (extra) check("busy_after_done_start", int'(busy), 0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, n, k;
        repeat (3) @(negedge clk);
        check("rst_latch", int'(nes_latch), 0);
        check("rst_clk", int'(nes_clk), 0);
        check("rst_buttons", int'(buttons), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;

        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (nes_latch || nes_clk || valid || busy) hi++;
        end
        check("idle_quiet", hi, 0);

        poll(8'h81, 1'b0, 1'b0, 1'b0, 2);
        poll(8'h00, 1'b1, 1'b1, 1'b0, 1);   // no pad
        poll(8'h00, 1'b1, 1'b0, 1'b0, 0);   // data stuck low
        poll(8'h5A, 1'b0, 1'b0, 1'b1, 0);   // extra starts ignored
        poll(8'h81, 1'b0, 1'b0, 1'b0, 0);
        poll(8'h10, 1'b0, 1'b0, 1'b0, 3);

        // Abort a poll during a CLOCK pulse
        pad_word = 8'hC3; pad_mode = 1'b0;
        start = 1'b1; n = cyc;
        sb.push_back('{8'hC3, n + BUSY_LEN});
        @(negedge clk); start = 1'b0;
        while (cyc < n + 30) @(negedge clk);
        check("clk_before_reset", int'(nes_clk), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_clk", int'(nes_clk), 0);
        check("async_rst_latch", int'(nes_latch), 0);
        check("async_rst_buttons", int'(buttons), 0);
        check("async_rst_busy", int'(busy), 0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        poll(8'h81, 1'b0, 1'b0, 1'b0, 1);

        repeat (12) begin
            poll(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
        end

        k = 0;
        while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
        check("scoreboard_drained", sb.size(), 0);
        check("valid_count", valid_cnt, n_polls);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
